// File: rtl/axi_rd_ram.sv
// rtl/axi_rd_ram.sv - AXI4 read-only slave returning bursts from a natively loaded word array.
module axi_rd_ram #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int AXI_ID_W    = 4,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_SIZE_W  = 3,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_LOCK_W  = 1,
  parameter int AXI_CACHE_W = 4,
  parameter int AXI_PROT_W  = 3,
  parameter int AXI_QOS_W   = 4,
  parameter int AXI_RESP_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [MEM_ADDR_W-1:0]  w_addr,
  input  logic [DATA_W-1:0]      w_data,
  input  logic [AXI_ID_W-1:0]    s_axi_arid,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]   s_axi_arlen,
  input  logic [AXI_SIZE_W-1:0]  s_axi_arsize,
  input  logic [AXI_BURST_W-1:0] s_axi_arburst,
  input  logic [AXI_LOCK_W-1:0]  s_axi_arlock,
  input  logic [AXI_CACHE_W-1:0] s_axi_arcache,
  input  logic [AXI_PROT_W-1:0]  s_axi_arprot,
  input  logic [AXI_QOS_W-1:0]   s_axi_arqos,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [AXI_ID_W-1:0]    s_axi_rid,
  output logic [DATA_W-1:0]      s_axi_rdata,
  output logic [AXI_RESP_W-1:0]  s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready
);

  localparam int BYTE_W = $clog2(DATA_W / 8);

  typedef enum logic {IDLE, DATA} state_t;

  state_t                 state, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [AXI_SIZE_W-1:0]  size_q, size_d;
  logic [AXI_BURST_W-1:0] burst_q, burst_d;
  logic                   err_q, err_d;
  logic                   arready_d, rvalid_d, rlast_d;
  logic [AXI_ID_W-1:0]    rid_d;
  logic [DATA_W-1:0]      rdata_d;
  logic [AXI_RESP_W-1:0]  rresp_d;

  logic [DATA_W-1:0]      mem [2**MEM_ADDR_W];

  logic [ADDR_W-1:0]      step, wrap_mask, next_addr;
  logic [MEM_ADDR_W-1:0]  ar_idx, next_idx;
  logic                   ar_err;
  logic                   unused_ok;

  assign unused_ok = &{1'b0, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  // Array is deliberately outside the reset domain so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  always_comb begin
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      2'd0:    next_addr = addr_q;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = addr_q + step;
    endcase
  end

  assign ar_idx   = s_axi_araddr[BYTE_W+MEM_ADDR_W-1:BYTE_W];
  assign next_idx = next_addr[BYTE_W+MEM_ADDR_W-1:BYTE_W];
  assign ar_err   = (int'(s_axi_arsize) > BYTE_W) || (s_axi_arburst == 2'd3) ||
                    ((s_axi_arburst == 2'd2) &&
                     !(s_axi_arlen inside {AXI_LEN_W'(1), AXI_LEN_W'(3), AXI_LEN_W'(7), AXI_LEN_W'(15)}));

  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rlast_d   = s_axi_rlast;
    rid_d     = s_axi_rid;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    case (state)
      IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          state_d   = DATA;
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          err_d     = ar_err;
          cnt_d     = '0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          rdata_d   = ar_err ? '0 : mem[ar_idx];
          rresp_d   = ar_err ? AXI_RESP_W'(2) : '0;
          rlast_d   = (s_axi_arlen == '0);
        end
      end
      DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (cnt_q == len_q) begin
            state_d   = IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + AXI_LEN_W'(1);
            addr_d  = next_addr;
            rdata_d = err_q ? '0 : mem[next_idx];
            rlast_d = ((cnt_q + AXI_LEN_W'(1)) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      err_q         <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      err_q         <= err_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rlast   <= rlast_d;
      s_axi_rid     <= rid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_ram.sv
// tb/tb_axi_rd_ram.sv - directed self-checking bench for axi_rd_ram.
module tb_axi_rd_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0;
  logic [9:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  arid = '0;
  logic [15:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic [0:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic [3:0]  arqos = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;
  int hold_err;
  logic [31:0] bd [16];
  logic        bl [16];
  logic [1:0]  br [16];
  logic [3:0]  bi [16];

  axi_rd_ram dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Issues one AR and collects beats; mode 0 keeps rready high, mode 1 toggles 1,0,0,...
  task automatic run_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           output int nbeats, output int ncyc, output bit tmo);
    logic        fire, pl;
    logic [31:0] pd;
    logic [1:0]  pr;
    int          w;
    tmo = 0; nbeats = 0; ncyc = 0; hold_err = 0; w = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && w < 20) begin @(posedge clk); #1; w++; end
    if (!arready) tmo = 1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (nbeats < int'(len) + 1 && ncyc < 100) begin
      rready = (mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
      fire = rvalid && rready;
      pd = rdata; pl = rlast; pr = rresp;
      if (fire && nbeats < 16) begin
        bd[nbeats] = rdata; bl[nbeats] = rlast; br[nbeats] = rresp; bi[nbeats] = rid;
      end
      if (fire) nbeats++;
      @(posedge clk); #1;
      ncyc++;
      if (!fire && (rdata !== pd || rlast !== pl || rresp !== pr)) hold_err++;
    end
    if (nbeats < int'(len) + 1) tmo = 1;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b expected 0", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b expected 0", rlast); end
    checks++; if (rresp !== 2'd0) begin errors++; $display("FAIL reset_rresp: got %0d expected 0", rresp); end
    checks++; if (rid !== 4'd0) begin errors++; $display("FAIL reset_rid: got %0d expected 0", rid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    rst = 1'b0;
    #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL release_arready_early: got %b expected 0", arready); end
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL release_arready: got %b expected 1", arready); end
  endtask

  task automatic preload;
    for (int k = 0; k < 16; k++) begin
      w_en = 1'b1; w_addr = 10'(k); w_data = 32'h100 + 32'(k);
      @(posedge clk); #1;
    end
    w_en = 1'b0;
  endtask

  task automatic test_incr;
    int n, c; bit t;
    run_burst(4'd1, 16'h0000, 8'd3, 3'd2, 2'd1, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 4) begin errors++; $display("FAIL incr_beats: got %0d timeout %0d expected 4", n, t); end
    checks++; if (c !== 4) begin errors++; $display("FAIL incr_cycles: got %0d expected 4", c); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bd[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL incr_data[%0d]: got %h expected %h", i, bd[i], 32'h100 + 32'(i)); end
      checks++; if (bl[i] !== (i == 3)) begin errors++; $display("FAIL incr_last[%0d]: got %b expected %b", i, bl[i], (i == 3)); end
      checks++; if (br[i] !== 2'd0) begin errors++; $display("FAIL incr_resp[%0d]: got %0d expected 0", i, br[i]); end
      checks++; if (bi[i] !== 4'd1) begin errors++; $display("FAIL incr_id[%0d]: got %0d expected 1", i, bi[i]); end
    end
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL incr_end: got rvalid %b arready %b expected 0 1", rvalid, arready); end
  endtask

  task automatic test_rready_toggle;
    int n, c; bit t;
    run_burst(4'd1, 16'h0000, 8'd3, 3'd2, 2'd1, 1, n, c, t);
    checks++; if (t !== 1'b0 || n !== 4) begin errors++; $display("FAIL toggle_beats: got %0d timeout %0d expected 4", n, t); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL toggle_hold: got %0d changes expected 0", hold_err); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bd[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, bd[i], 32'h100 + 32'(i)); end
      checks++; if (bl[i] !== (i == 3)) begin errors++; $display("FAIL toggle_last[%0d]: got %b expected %b", i, bl[i], (i == 3)); end
    end
  endtask

  task automatic test_wrap_fixed;
    int n, c; bit t;
    logic [31:0] exp_wrap [4];
    exp_wrap[0] = 32'h106; exp_wrap[1] = 32'h107; exp_wrap[2] = 32'h104; exp_wrap[3] = 32'h105;
    run_burst(4'd2, 16'h0018, 8'd3, 3'd2, 2'd2, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 4) begin errors++; $display("FAIL wrap_beats: got %0d timeout %0d expected 4", n, t); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bd[i] !== exp_wrap[i] || br[i] !== 2'd0) begin errors++; $display("FAIL wrap_data[%0d]: got %h resp %0d expected %h resp 0", i, bd[i], br[i], exp_wrap[i]); end
    end
    run_burst(4'd3, 16'h0008, 8'd2, 3'd2, 2'd0, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 3) begin errors++; $display("FAIL fixed_beats: got %0d timeout %0d expected 3", n, t); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bd[i] !== 32'h102 || bl[i] !== (i == 2)) begin errors++; $display("FAIL fixed_data[%0d]: got %h last %b expected 102 last %b", i, bd[i], bl[i], (i == 2)); end
    end
  endtask

  task automatic test_slverr;
    int n, c; bit t;
    run_burst(4'd1, 16'h0000, 8'd1, 3'd3, 2'd1, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 2) begin errors++; $display("FAIL size_err_beats: got %0d timeout %0d expected 2", n, t); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bd[i] !== 32'd0 || br[i] !== 2'd2 || bl[i] !== (i == 1)) begin errors++; $display("FAIL size_err[%0d]: got data %h resp %0d last %b expected 0 2 %b", i, bd[i], br[i], bl[i], (i == 1)); end
    end
    run_burst(4'd1, 16'h0010, 8'd0, 3'd2, 2'd1, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 1 || bd[0] !== 32'h104 || br[0] !== 2'd0 || bl[0] !== 1'b1) begin errors++; $display("FAIL after_err: got data %h resp %0d last %b expected 104 0 1", bd[0], br[0], bl[0]); end
    run_burst(4'd4, 16'h0000, 8'd2, 3'd2, 2'd2, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 3) begin errors++; $display("FAIL wrap_len_err_beats: got %0d timeout %0d expected 3", n, t); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bd[i] !== 32'd0 || br[i] !== 2'd2 || bl[i] !== (i == 2)) begin errors++; $display("FAIL wrap_len_err[%0d]: got data %h resp %0d last %b expected 0 2 %b", i, bd[i], br[i], bl[i], (i == 2)); end
    end
    run_burst(4'd4, 16'h0004, 8'd0, 3'd2, 2'd3, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 1 || bd[0] !== 32'd0 || br[0] !== 2'd2) begin errors++; $display("FAIL burst3_err: got data %h resp %0d expected 0 2", bd[0], br[0]); end
  endtask

  task automatic test_back_to_back;
    int hs1, hs2, lastm, viol;
    logic [31:0] d2;
    hs1 = -1; hs2 = -1; lastm = -1; viol = 0; d2 = '0;
    arid = 4'd2; araddr = 16'h0000; arlen = 8'd1; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b1;
    for (int e = 0; e < 10; e++) begin
      if (arvalid && arready) begin
        if (hs1 < 0) hs1 = e; else if (hs2 < 0) hs2 = e;
      end
      if (rvalid && rready && rlast && lastm < 0) lastm = e;
      if (rvalid && arready) viol++;
      @(posedge clk); #1;
      if (hs1 == e) begin araddr = 16'h0020; arlen = 8'd0; arid = 4'd3; end
      if (hs2 == e) begin d2 = rdata; arvalid = 1'b0; end
    end
    arvalid = 1'b0; rready = 1'b0;
    checks++; if (hs1 !== 0 || lastm !== 2) begin errors++; $display("FAIL b2b_first: got hs %0d last %0d expected 0 2", hs1, lastm); end
    checks++; if (hs2 !== lastm + 1) begin errors++; $display("FAIL b2b_second_hs: got %0d expected %0d", hs2, lastm + 1); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_arready_in_data: got %0d cycles expected 0", viol); end
    checks++; if (d2 !== 32'h108) begin errors++; $display("FAIL b2b_second_data: got %h expected 108", d2); end
  endtask

  task automatic test_reset_mid_burst;
    int n, c; bit t;
    arid = 4'd5; araddr = 16'h0000; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h102) begin errors++; $display("FAIL mid_beat2: got valid %b data %h expected 1 102", rvalid, rdata); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({arready, rvalid, rlast, rresp, rid, rdata} !== '0) begin errors++; $display("FAIL mid_async_clear: got ar %b v %b l %b resp %0d id %0d data %h expected all 0", arready, rvalid, rlast, rresp, rid, rdata); end
    rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL mid_arready_early: got %b expected 0", arready); end
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL mid_arready: got %b expected 1", arready); end
    run_burst(4'd6, 16'h0000, 8'd3, 3'd2, 2'd1, 0, n, c, t);
    checks++; if (t !== 1'b0 || n !== 4) begin errors++; $display("FAIL reread_beats: got %0d timeout %0d expected 4", n, t); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bd[i] !== 32'h100 + 32'(i) || bi[i] !== 4'd6) begin errors++; $display("FAIL reread_data[%0d]: got %h id %0d expected %h id 6", i, bd[i], bi[i], 32'h100 + 32'(i)); end
    end
  endtask

  task automatic test_collision;
    int n, c; bit t;
    arid = 4'd7; araddr = 16'h0000; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    w_en = 1'b1; w_addr = 10'd0; w_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    arvalid = 1'b0; w_en = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h100) begin errors++; $display("FAIL collision_old: got valid %b data %h expected 1 100", rvalid, rdata); end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL collision_end: got rvalid %b expected 0", rvalid); end
    run_burst(4'd7, 16'h0000, 8'd0, 3'd2, 2'd1, 0, n, c, t);
    checks++; if (t !== 1'b0 || bd[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collision_new: got %h timeout %0d expected deadbeef", bd[0], t); end
  endtask

  initial begin
    test_reset();
    preload();
    test_incr();
    test_rready_toggle();
    test_wrap_fixed();
    test_slverr();
    test_back_to_back();
    test_reset_mid_burst();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_ram.md
# axi_rd_ram

AXI4 read-only slave backed by an internal word array. It sits directly downstream of `iob2axi_rd`: it accepts that master's AR request and returns an R burst. It is the memory end of the native-to-AXI read path in simulation benches and small FPGA subsystems. A native write port loads the array, either as a backdoor or from a writer block.

## Interface
Parameters:
- `ADDR_W`, 16, AXI byte-address width.
- `DATA_W`, 32, AXI data width in bits (8..1024, power of two).
- `MEM_ADDR_W`, 10, log2 of array depth in words.

Ports:
- `clk`  in  1  clock. Everything is sampled on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `w_en`  in  1  native write strobe (one word per cycle).
- `w_addr`  in  MEM_ADDR_W  word index for the native write.
- `w_data`  in  DATA_W  word to write.
- `s_axi_arid`  in  `AXI_ID_W`  request ID.
- `s_axi_araddr`  in  ADDR_W  start byte address.
- `s_axi_arlen`  in  `AXI_LEN_W` (8)  beats − 1.
- `s_axi_arsize`  in  `AXI_SIZE_W` (3)  log2 of bytes per beat.
- `s_axi_arburst`  in  `AXI_BURST_W` (2)  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- `s_axi_arlock`, `s_axi_arcache`, `s_axi_arprot`, `s_axi_arqos`  in  macro widths  ignored.
- `s_axi_arvalid`  in  1  AR valid.
- `s_axi_arready`  out  1  AR ready (registered).
- `s_axi_rid`  out  `AXI_ID_W`  echoes the latched arid.
- `s_axi_rdata`  out  DATA_W  beat data (registered).
- `s_axi_rresp`  out  `AXI_RESP_W` (2)  0 OKAY, 2 SLVERR.
- `s_axi_rlast`  out  1  marks the final beat.
- `s_axi_rvalid`  out  1  R valid (registered).
- `s_axi_rready`  in  1  R ready.

## Operation
State machine has two states: IDLE and DATA. Reset state is IDLE.

IDLE:
- `arready`=1.
- On `arvalid & arready`, latch araddr, arlen, arsize, arburst and arid, clear the beat counter, and go to DATA.
- On the same edge: `arready`<=0, `rvalid`<=1, and the rdata, rresp and rlast outputs are loaded for beat 0.

DATA:
- Beat `i` is presented until `rvalid & rready`.
- On each handshake that is not the last, load beat `i+1` on the same edge. Outputs never change while `rvalid & !rready`.
- On the handshake of the beat where counter == len (the last beat): `rvalid`<=0, `rlast`<=0, `arready`<=1, go to IDLE.

Beat address rules (byte address A, step S = 2^arsize):
- INCR: A += S per beat. Carry beyond ADDR_W is dropped.
- FIXED: A is held for every beat.
- WRAP: boundary = (len+1)·S. A increments and wraps to the aligned base `floor(A0/boundary)·boundary`.
- Word index = A[log2(DATA_W/8) + MEM_ADDR_W − 1 : log2(DATA_W/8)]. Upper address bits are ignored (aliasing). The low bits select nothing: the full word is returned for every size.

Error handling:
- SLVERR applies to the whole burst when arsize > log2(DATA_W/8), arburst == 3, or WRAP with len ∉ {1, 3, 7, 15}.
- On SLVERR the block still returns exactly len+1 beats with rdata = 0, rresp = 2, and correct rlast.

Native write:
- `w_en` writes `mem[w_addr]` at the edge.
- The write is independent of AXI state and is accepted every cycle.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. `arready` rises at the first clock edge after `rst` falls.
- Array contents are not reset. They are retained across a mid-burst reset.
- Latency: AR handshake at edge N → beat 0 valid from edge N through edge N+1.
- Throughput: one beat per cycle while rready=1.
- Turnaround: last R handshake at edge M → arready=1 after M → earliest next AR handshake at M+1. This is a one-cycle bubble.
- `arvalid` is ignored in DATA; the block has no AR queue.
- Array reads are combinational from the array and captured into rdata.
- Write/read collision: if `w_en` targets the word loaded at the same edge, the old value is returned; the new value is visible from the next edge.
- Reset mid-burst clears all outputs and returns the block to IDLE immediately (asynchronous). The remaining beats are dropped.

## Test plan
- Load mem[k]=k+0x100 for k=0..15; INCR, addr 0x0, len 3, size 2, arid=1, rready=1 → beats 0x100..0x103 on 4 consecutive cycles, rlast on beat 4, rresp=0, rid=1.
- Same burst with rready toggling 1,0,0,1,… → data, rlast and rresp hold while rready=0; no beat is skipped or duplicated.
- WRAP, addr 0x18, len 3, size 2 (DATA_W=32) → words 6, 7, 4, 5; FIXED, addr 0x8, len 2 → word 2 three times.
- arsize=3 with DATA_W=32, len 1 → two beats with rdata=0, rresp=2, rlast on the second beat; the next OKAY burst is unaffected.
- Back-to-back AR with arvalid held high → second handshake exactly one cycle after the first burst's last beat; arready=0 throughout DATA.
- Assert rst during beat 2 of len 7 → all outputs 0 asynchronously, arready=1 one edge after release; a re-read returns the preloaded values (array intact). Also write word 0 in the same cycle beat 0 is loaded → old value returned.
